result_checker: RTL and testbench

Output-side companion to the stimulus generator in the FP multiplier benches. It receives the DUT result stream, realigns it to the input-side valid and expected-value stream through a LATENCY-deep delay line, and bit-compares each result. It reports a sticky error, mismatch and sample counts, and the index of the first failing sample. It signals completion once END_SIM has been seen and the pipeline has drained.

---
 rtl/result_checker.sv | 123 ++++++++++++
 tb/tb_result_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_checker.sv
// rtl/result_checker.sv - realigns DUT results to a delayed expected stream and bit-compares them
module result_checker #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             VIN,
  input  logic [WIDTH-1:0] EXP_IN,
  input  logic [WIDTH-1:0] DUT_OUT,
  input  logic             END_SIM,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] SMP_CNT,
  output logic [CNT_W-1:0] FIRST_ERR_IDX,
  output logic             DONE
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int              DW         = $clog2(LATENCY + 1);
  localparam logic [DW-1:0]   DRAIN_LOAD = DW'(LATENCY);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [1:0]         state;
  logic [DW-1:0]      drain_cnt;
  logic [LATENCY-1:0] v_q;
  logic [WIDTH-1:0]   exp_q [LATENCY];
  logic               load_v;
  logic               cmp;
  logic               mis;

  // END_SIM wins over VIN only while idle; in RUN the closing sample still enters the line
  always_comb begin
    load_v = 1'b0;
    case (state)
      S_IDLE:  load_v = VIN & ~END_SIM;
      S_RUN:   load_v = VIN;
      default: load_v = 1'b0;
    endcase
  end

  assign cmp  = v_q[LATENCY-1] && (state != S_DONE);
  assign mis  = cmp && (DUT_OUT != exp_q[LATENCY-1]);
  assign DONE = (state == S_DONE);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      v_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        exp_q[i] <= '0;
      end
    end else begin
      v_q[0]   <= load_v;
      exp_q[0] <= EXP_IN;
      for (int i = 1; i < LATENCY; i++) begin
        v_q[i]   <= v_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (END_SIM) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else if (VIN) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (END_SIM) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Counters stick at all-ones; ERR is independent of ERR_CNT saturation
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ERR           <= 1'b0;
      ERR_CNT       <= '0;
      SMP_CNT       <= '0;
      FIRST_ERR_IDX <= '0;
    end else if (cmp) begin
      if (SMP_CNT != CNT_MAX) begin
        SMP_CNT <= SMP_CNT + 1'b1;
      end
      if (mis) begin
        ERR <= 1'b1;
        if (ERR_CNT != CNT_MAX) begin
          ERR_CNT <= ERR_CNT + 1'b1;
        end
        if (!ERR) begin
          FIRST_ERR_IDX <= SMP_CNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_checker.sv
// tb/tb_result_checker.sv - scoreboard bench for result_checker with a 4-stage model DUT
module tb_result_checker;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 4;
  localparam int CNT_W   = 16;

  logic             CLK;
  logic             RST_n;
  logic             VIN;
  logic [WIDTH-1:0] EXP_IN;
  logic [WIDTH-1:0] DUT_OUT;
  logic             END_SIM;
  logic             ERR;
  logic [CNT_W-1:0] ERR_CNT;
  logic [CNT_W-1:0] SMP_CNT;
  logic [CNT_W-1:0] FIRST_ERR_IDX;
  logic             DONE;

  logic             vin_s;
  logic             end_s;
  logic [WIDTH-1:0] exp_s;
  logic [WIDTH-1:0] dut_s;
  logic             err_s;
  logic [3:0]       err_cnt_s;
  logic [3:0]       smp_cnt_s;
  logic [3:0]       first_s;
  logic             done_s;

  logic             flip_in;
  logic [WIDTH-1:0] pipe [LATENCY];

  int vectors;
  int miscompares;
  logic sb [$];
  logic started;
  logic ended;

  result_checker #(.WIDTH(WIDTH), .LATENCY(LATENCY), .CNT_W(CNT_W)) u_dut (
    .CLK(CLK), .RST_n(RST_n), .VIN(VIN), .EXP_IN(EXP_IN), .DUT_OUT(DUT_OUT),
    .END_SIM(END_SIM), .ERR(ERR), .ERR_CNT(ERR_CNT), .SMP_CNT(SMP_CNT),
    .FIRST_ERR_IDX(FIRST_ERR_IDX), .DONE(DONE)
  );

  result_checker #(.WIDTH(WIDTH), .LATENCY(LATENCY), .CNT_W(4)) u_sat (
    .CLK(CLK), .RST_n(RST_n), .VIN(vin_s), .EXP_IN(exp_s), .DUT_OUT(dut_s),
    .END_SIM(end_s), .ERR(err_s), .ERR_CNT(err_cnt_s), .SMP_CNT(smp_cnt_s),
    .FIRST_ERR_IDX(first_s), .DONE(done_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model DUT: four registers, optional bit-0 corruption applied at entry
  always @(posedge CLK) begin
    pipe[0] <= EXP_IN ^ {{(WIDTH-1){1'b0}}, flip_in};
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign DUT_OUT = pipe[LATENCY-1];
  assign exp_s   = '0;
  assign dut_s   = 32'h1;

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every SMP_CNT step is one compare event; pop its expected outcome
  int   prev_smp;
  int   prev_ecnt;
  logic exp_err;
  int   exp_first;
  always @(negedge CLK) begin
    if (!RST_n) begin
      prev_smp  = 0;
      prev_ecnt = 0;
      exp_err   = 1'b0;
      exp_first = 0;
    end else if (int'(SMP_CNT) != prev_smp) begin
      logic m;
      check("smp_step", SMP_CNT, prev_smp + 1);
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_compare: SMP_CNT=%0d, expected no compare", SMP_CNT);
      end else begin
        m = sb.pop_front();
        if (m && !exp_err) begin
          exp_err   = 1'b1;
          exp_first = prev_smp;
        end
        check("err_cnt_step", ERR_CNT, prev_ecnt + int'(m));
        check("err_flag", ERR, exp_err);
        if (exp_err) check("first_err_idx", FIRST_ERR_IDX, exp_first);
      end
      prev_smp  = int'(SMP_CNT);
      prev_ecnt = int'(ERR_CNT);
    end
  end

  task automatic step(input logic vin, input logic [WIDTH-1:0] e, input logic flip, input logic es);
    logic counted;
    counted = vin && !ended && !(es && !started);
    VIN = vin; EXP_IN = e; flip_in = flip; END_SIM = es;
    if (counted) sb.push_back(flip);
    @(posedge CLK); #1;
    if (counted) started = 1'b1;
    if (es) ended = 1'b1;
  endtask

  task automatic do_reset();
    #2 RST_n = 1'b0;
    #1;
    check("rst_smp_cnt", SMP_CNT, 0);
    check("rst_err", ERR, 0);
    check("rst_done", DONE, 0);
    sb.delete();
    started = 1'b0;
    ended   = 1'b0;
    VIN = 1'b0; END_SIM = 1'b0; flip_in = 1'b0;
    @(posedge CLK); #1;
    RST_n = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!DONE && n < 20) begin
      step(1'b0, '0, 1'b0, 1'b0);
      n++;
    end
    check(name, DONE, 1);
  endtask

  function automatic logic [WIDTH-1:0] pat(input int i);
    return 32'h1357_0000 + 32'h0101_0101 * i;
  endfunction

  initial begin
    logic [6:0] gaps;
    vectors = 0; miscompares = 0;
    RST_n = 1'b0; VIN = 1'b0; EXP_IN = '0; END_SIM = 1'b0; flip_in = 1'b0;
    vin_s = 1'b0; end_s = 1'b0; started = 1'b0; ended = 1'b0;
    #1;
    check("init_err_cnt", ERR_CNT, 0);
    check("init_first_idx", FIRST_ERR_IDX, 0);
    check("init_done", DONE, 0);
    @(posedge CLK); #1;
    RST_n = 1'b1;

    // 10 clean back-to-back samples; DONE on the 5th edge counting the END_SIM edge
    for (int i = 0; i < 10; i++) step(1'b1, pat(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
    check("t1_done_edge4", DONE, 0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("t1_done_edge5", DONE, 1);
    check("t1_smp_cnt", SMP_CNT, 10);
    check("t1_err", ERR, 0);
    check("t1_err_cnt", ERR_CNT, 0);
    check("t1_sb_empty", sb.size(), 0);

    // Corrupt samples 3 and 7
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, pat(i + 20), (i == 3 || i == 7), 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    wait_done("t2_done");
    check("t2_err", ERR, 1);
    check("t2_err_cnt", ERR_CNT, 2);
    check("t2_first_idx", FIRST_ERR_IDX, 3);
    check("t2_smp_cnt", SMP_CNT, 10);
    check("t2_sb_empty", sb.size(), 0);

    // Gapped VIN 1,0,0,1,1,0,1
    do_reset();
    gaps = 7'b1011001;
    for (int i = 0; i < 7; i++) step(gaps[i], pat(i + 40), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    wait_done("t3_done");
    check("t3_smp_cnt", SMP_CNT, 4);
    check("t3_err", ERR, 0);
    check("t3_sb_empty", sb.size(), 0);

    // Mid-run async reset discards three in-flight samples
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, pat(i + 60), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    #1 RST_n = 1'b0;
    sb.delete();
    started = 1'b0;
    ended   = 1'b0;
    #1;
    check("t4_rst_smp_cnt", SMP_CNT, 0);
    check("t4_rst_err_cnt", ERR_CNT, 0);
    #3 RST_n = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 2; i++) step(1'b1, pat(i + 70), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    wait_done("t4_done");
    check("t4_smp_cnt", SMP_CNT, 2);
    check("t4_err", ERR, 0);
    check("t4_sb_empty", sb.size(), 0);

    // END_SIM with the last VIN, then VIN pulses during drain and after DONE
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, pat(i + 80), 1'b0, 1'b0);
    step(1'b1, pat(84), 1'b0, 1'b1);
    step(1'b1, pat(85), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, pat(86), 1'b1, 1'b0);
    wait_done("t5_done");
    check("t5_smp_cnt", SMP_CNT, 5);
    for (int i = 0; i < 6; i++) step(1'b1, pat(i + 90), 1'b1, (i == 2));
    check("t5_done_sticky", DONE, 1);
    check("t5_smp_cnt_hold", SMP_CNT, 5);
    check("t5_err_hold", ERR, 0);

    // CNT_W=4 instance: 20 mismatching samples saturate at 15
    do_reset();
    for (int i = 0; i < 20; i++) begin
      vin_s = 1'b1;
      @(posedge CLK); #1;
    end
    vin_s = 1'b0;
    end_s = 1'b1;
    @(posedge CLK); #1;
    end_s = 1'b0;
    for (int i = 0; i < 20 && !done_s; i++) begin
      @(posedge CLK); #1;
    end
    check("t6_done", done_s, 1);
    check("t6_err_cnt_sat", err_cnt_s, 15);
    check("t6_smp_cnt_sat", smp_cnt_s, 15);
    check("t6_err", err_s, 1);
    check("t6_first_idx", first_s, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
